// File: rtl/div_stall_unit_if.sv
// EX-stage divider bus: issue-side operands/controls and the stall/result returns.
interface div_stall_unit_if #(
    parameter int WIDTH = 32
);
    logic             startE;
    logic             signedE;
    logic [WIDTH-1:0] srcaE;
    logic [WIDTH-1:0] srcbE;
    logic             cancel;
    logic             stall_div;
    logic             busy;
    logic             result_valid;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output startE, signedE, srcaE, srcbE, cancel,
        input  stall_div, busy, result_valid, hi_o, lo_o
    );

    modport slave (
        input  startE, signedE, srcaE, srcbE, cancel,
        output stall_div, busy, result_valid, hi_o, lo_o
    );
endinterface

// File: rtl/div_stall_unit.sv
// Iterative restoring DIV/DIVU (one quotient bit per cycle) with a pipeline
// stall request that holds F/D/E until the HI/LO result is ready.
module div_stall_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic            clk,
    input logic            resetn,
    div_stall_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] dividend_raw;
    logic             neg_q;
    logic             neg_r;
    logic             dvs_zero;

    logic             start_ok;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quot_next;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    always_comb begin
        start_ok      = bus.startE & ~bus.cancel & (state != BUSY);
        bus.stall_div = start_ok | (state == BUSY);

        mag_a = (bus.signedE & bus.srcaE[WIDTH-1]) ? -bus.srcaE : bus.srcaE;
        mag_b = (bus.signedE & bus.srcbE[WIDTH-1]) ? -bus.srcbE : bus.srcbE;

        // {rem, quot} shifts left as one register; quot collects quotient bits in its LSB.
        trial = {rem, quot[WIDTH-1]};
        diff  = trial - {1'b0, dvs};
        if (!diff[WIDTH]) begin
            rem_next  = diff[WIDTH-1:0];
            quot_next = {quot[WIDTH-2:0], 1'b1};
        end else begin
            rem_next  = trial[WIDTH-1:0];
            quot_next = {quot[WIDTH-2:0], 1'b0};
        end

        q_fix = neg_q ? -quot_next : quot_next;
        r_fix = neg_r ? -rem_next  : rem_next;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state            <= IDLE;
            count            <= '0;
            rem              <= '0;
            quot             <= '0;
            dvs              <= '0;
            dividend_raw     <= '0;
            neg_q            <= 1'b0;
            neg_r            <= 1'b0;
            dvs_zero         <= 1'b0;
            bus.busy         <= 1'b0;
            bus.result_valid <= 1'b0;
            bus.hi_o         <= '0;
            bus.lo_o         <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    bus.result_valid <= 1'b0;
                    if (start_ok) begin
                        state        <= BUSY;
                        bus.busy     <= 1'b1;
                        count        <= '0;
                        rem          <= '0;
                        quot         <= mag_a;
                        dvs          <= mag_b;
                        dividend_raw <= bus.srcaE;
                        dvs_zero     <= (bus.srcbE == '0);
                        neg_q        <= bus.signedE & (bus.srcaE[WIDTH-1] ^ bus.srcbE[WIDTH-1]);
                        neg_r        <= bus.signedE & bus.srcaE[WIDTH-1];
                    end else begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                BUSY: begin
                    if (bus.cancel) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end else begin
                        rem   <= rem_next;
                        quot  <= quot_next;
                        count <= count + CNT_W'(1);
                        if (count == CNT_W'(WIDTH - 1)) begin
                            state            <= DONE;
                            bus.busy         <= 1'b0;
                            bus.result_valid <= 1'b1;
                            if (dvs_zero) begin
                                bus.lo_o <= '1;
                                bus.hi_o <= dividend_raw;
                            end else begin
                                bus.lo_o <= q_fix;
                                bus.hi_o <= r_fix;
                            end
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
